// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared types and default constants for the repeated-addition
//               multiplier front end (operand sequencer and run counter).
// Contents    : seq_state_t   - sequencer state encoding
//               c_def_width   - default operand width
//               c_def_max_cyc - default RUN-state cycle limit before timeout
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

  localparam int unsigned c_def_width   = 16;
  localparam int unsigned c_def_max_cyc = 2**16 + 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    HOLD  = 3'd4
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/mul_operand_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_operand_sequencer_if
// Description : Bundles the operand input stream, the multiplier-core control
//               and data bus, and the product output stream.
// Modports    : slave  - the sequencer (accepts operands, drives the core,
//                        returns the product)
//               master - the environment (operand source, core, consumer)
// Signals     : in_valid/in_ready/in_a/in_b       operand pair handshake
//               core_clr/start/data_in            sequencer -> core
//               lda/ldb/done/core_p               core -> sequencer
//               out_valid/out_ready/out_product/
//               out_err/out_cycles                result handshake
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_operand_sequencer_if import mul_pkg::*; #(
  parameter int unsigned WIDTH = c_def_width
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 core_clr;
  logic                 start;
  logic [WIDTH-1:0]     data_in;
  logic                 lda;
  logic                 ldb;
  logic                 done;
  logic [2*WIDTH-1:0]   core_p;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;
  logic                 out_err;
  logic [31:0]          out_cycles;

  modport slave (
    input  in_valid, in_a, in_b, lda, ldb, done, core_p, out_ready,
    output in_ready, core_clr, start, data_in,
           out_valid, out_product, out_err, out_cycles
  );

  modport master (
    output in_valid, in_a, in_b, lda, ldb, done, core_p, out_ready,
    input  in_ready, core_clr, start, data_in,
           out_valid, out_product, out_err, out_cycles
  );

endinterface
`default_nettype wire

// File: rtl/mul_run_counter.sv
`default_nettype none
// ============================================================================
// Module      : mul_run_counter
// Description : 32-bit saturating cycle counter with synchronous clear and
//               count enable. o_hit flags the last cycle before the limit.
// Ports       : clk    - clock, rising edge
//               rst_n  - synchronous active-low reset
//               i_clr  - clear to 0 (has priority over i_en)
//               i_en   - count one step this cycle
//               o_cnt  - current count, saturates at LIMIT
//               o_hit  - o_cnt == LIMIT-1
// Revision    : 1.0 - initial release
// ============================================================================
module mul_run_counter import mul_pkg::*; #(
  parameter int unsigned LIMIT = c_def_max_cyc
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        i_clr,
  input  wire logic        i_en,
  output logic [31:0]      o_cnt,
  output logic             o_hit
);

  localparam logic [31:0] c_limit = 32'(LIMIT);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != c_limit)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;
  assign o_hit = (cnt_q == (c_limit - 32'd1));

endmodule
`default_nettype wire

// File: rtl/mul_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mul_operand_sequencer
// Description : Front end of the repeated-addition multiplier. Accepts an
//               operand pair, clears the core, feeds A/B onto the core's
//               shared data bus in step with lda/ldb, starts the core, waits
//               for done (or times out) and returns the product. B=0 is
//               answered directly since the core's count-down loop would
//               never terminate on it.
// Ports       : clk    - clock, rising edge
//               rst_n  - synchronous active-low reset
//               bus    - slave view of mul_operand_sequencer_if
// Revision    : 1.0 - initial release
// ============================================================================
module mul_operand_sequencer import mul_pkg::*; #(
  parameter int unsigned WIDTH   = c_def_width,
  parameter int unsigned MAX_CYC = c_def_max_cyc
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  mul_operand_sequencer_if.slave  bus
);

  seq_state_t           state_q,       state_d;
  logic [WIDTH-1:0]     a_q,           a_d;
  logic [WIDTH-1:0]     b_q,           b_d;
  logic                 core_clr_q,    core_clr_d;
  logic                 start_q,       start_d;
  logic                 out_valid_q,   out_valid_d;
  logic [2*WIDTH-1:0]   out_product_q, out_product_d;
  logic                 out_err_q,     out_err_d;
  logic [31:0]          out_cycles_q,  out_cycles_d;

  logic [31:0]          w_run_cnt;
  logic                 w_run_hit;

  // Counter restarts while in CLEAR so it reads 0 on entry to START.
  mul_run_counter #(
    .LIMIT (MAX_CYC)
  ) u_run_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (state_q == CLEAR),
    .i_en  (state_q == RUN),
    .o_cnt (w_run_cnt),
    .o_hit (w_run_hit)
  );

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    core_clr_d    = 1'b0;
    start_d       = 1'b0;
    out_valid_d   = 1'b0;
    out_product_d = out_product_q;
    out_err_d     = out_err_q;
    out_cycles_d  = out_cycles_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d = bus.in_a;
          b_d = bus.in_b;
          if (bus.in_b == '0) begin
            out_product_d = '0;
            out_err_d     = 1'b0;
            out_cycles_d  = '0;
            out_valid_d   = 1'b1;
            state_d       = HOLD;
          end else begin
            core_clr_d = 1'b1;
            state_d    = CLEAR;
          end
        end
      end
      CLEAR: begin
        start_d = 1'b1;
        state_d = START;
      end
      START: begin
        // start stays up until the core acknowledges by loading A.
        if (bus.lda) begin
          state_d = RUN;
        end else begin
          start_d = 1'b1;
        end
      end
      RUN: begin
        // done takes priority over a timeout landing in the same cycle.
        if (bus.done) begin
          out_product_d = bus.core_p;
          out_err_d     = 1'b0;
          out_cycles_d  = w_run_cnt;
          out_valid_d   = 1'b1;
          state_d       = HOLD;
        end else if (w_run_hit) begin
          out_product_d = '0;
          out_err_d     = 1'b1;
          out_cycles_d  = 32'(MAX_CYC);
          out_valid_d   = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      core_clr_q    <= 1'b0;
      start_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      out_err_q     <= 1'b0;
      out_cycles_q  <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      core_clr_q    <= core_clr_d;
      start_q       <= start_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
      out_err_q     <= out_err_d;
      out_cycles_q  <= out_cycles_d;
    end
  end

  // Shared core operand bus: B only while the core loads B (also when both
  // strobes are wrongly high), otherwise A.
  always_comb begin
    if (bus.ldb) begin
      bus.data_in = b_q;
    end else begin
      bus.data_in = a_q;
    end
  end

  assign bus.in_ready    = (state_q == IDLE) && rst_n;
  assign bus.core_clr    = core_clr_q;
  assign bus.start       = start_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_product = out_product_q;
  assign bus.out_err     = out_err_q;
  assign bus.out_cycles  = out_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_operand_sequencer
// Description : Self-checking bench for mul_operand_sequencer with a
//               behavioural repeated-addition core. Expected results are
//               queued at operand acceptance and compared at the product
//               handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_operand_sequencer;
  import mul_pkg::*;

  localparam int W  = 16;
  localparam int MC = 32;

  typedef struct {
    logic [2*W-1:0] p;
    logic           err;
    logic [31:0]    cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    logic [31:0]    cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic core_rst = 1'b1;
  logic hang = 1'b0;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  logic [W-1:0]   cur_a = '0;
  logic [W-1:0]   cur_b = '0;
  logic [2*W-1:0] cur_p = '0;
  logic           cur_err = 1'b0;
  logic [31:0]    cur_cyc = '0;

  always #5 clk = ~clk;

  mul_operand_sequencer_if #(.WIDTH(W)) bus();

  mul_operand_sequencer #(
    .WIDTH   (W),
    .MAX_CYC (MC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural core: after start it loads A then B from data_in, then adds
  // A into P once per cycle while counting B down; done when B reaches 0.
  logic [W-1:0] ca;
  logic [W-1:0] cb;
  int           cst;

  always_ff @(posedge clk) begin
    if (core_rst || bus.core_clr) begin
      cst         <= 0;
      bus.lda     <= 1'b0;
      bus.ldb     <= 1'b0;
      bus.done    <= 1'b0;
      bus.core_p  <= '0;
      ca          <= '0;
      cb          <= '0;
    end else begin
      case (cst)
        0: if (bus.start) begin
          bus.lda <= 1'b1;
          cst     <= 1;
        end
        1: begin
          ca      <= bus.data_in;
          bus.lda <= 1'b0;
          bus.ldb <= 1'b1;
          cst     <= 2;
        end
        2: begin
          cb      <= bus.data_in;
          bus.ldb <= 1'b0;
          cst     <= 3;
        end
        3: begin
          if (cb == '0) begin
            if (!hang) begin
              bus.done <= 1'b1;
              cst      <= 4;
            end
          end else begin
            bus.core_p <= bus.core_p + {{W{1'b0}}, ca};
            cb         <= cb - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst_n && bus.lda) chk("data_in_lda", 64'(bus.data_in), 64'(cur_a));
    if (rst_n && bus.ldb) chk("data_in_ldb", 64'(bus.data_in), 64'(cur_b));
    if (rst_n && bus.in_valid && bus.in_ready) begin
      exp_q.push_back('{p: cur_p, err: cur_err, cyc: cur_cyc});
    end
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got product %0d, expected no result", bus.out_product);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_product", 64'(bus.out_product), 64'(e.p));
        chk("out_err", 64'(bus.out_err), 64'(e.err));
        chk("out_cycles", 64'(bus.out_cycles), 64'(e.cyc));
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] p, input logic err, input logic [31:0] cyc);
    int n = 0;
    @(posedge clk);
    #1;
    cur_a = a; cur_b = b; cur_p = p; cur_err = err; cur_cyc = cyc;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: %0d results pending, expected 0 after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{a: 16'd3,     b: 16'd4, p: 32'd12,     cyc: 32'd6};
    vecs[1] = '{a: 16'd7,     b: 16'd0, p: 32'd0,      cyc: 32'd0};
    vecs[2] = '{a: 16'd1,     b: 16'd1, p: 32'd1,      cyc: 32'd3};
    vecs[3] = '{a: 16'd0,     b: 16'd5, p: 32'd0,      cyc: 32'd7};
    vecs[4] = '{a: 16'd65535, b: 16'd3, p: 32'd196605, cyc: 32'd5};
    vecs[5] = '{a: 16'd12,    b: 16'd2, p: 32'd24,     cyc: 32'd4};
    vecs[6] = '{a: 16'd6,     b: 16'd9, p: 32'd54,     cyc: 32'd11};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    core_rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_core_clr", 64'(bus.core_clr), 64'd0);
    chk("rst_start", 64'(bus.start), 64'd0);
    chk("rst_data_in", 64'(bus.data_in), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_product", 64'(bus.out_product), 64'd0);
    chk("rst_out_err", 64'(bus.out_err), 64'd0);
    chk("rst_out_cycles", 64'(bus.out_cycles), 64'd0);

    // 3x4: clear pulse the cycle after accept, start the cycle after that
    send(16'd3, 16'd4, 32'd12, 1'b0, 32'd6);
    @(negedge clk);
    chk("clr_pulse", 64'(bus.core_clr), 64'd1);
    chk("no_start_in_clear", 64'(bus.start), 64'd0);
    @(negedge clk);
    chk("clr_single", 64'(bus.core_clr), 64'd0);
    chk("start_after_clear", 64'(bus.start), 64'd1);
    wait_result(200);

    // 7x0 bypass: result one cycle after accept, core untouched
    send(16'd7, 16'd0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("bypass_out_valid", 64'(bus.out_valid), 64'd1);
    chk("bypass_no_clr", 64'(bus.core_clr), 64'd0);
    chk("bypass_no_start", 64'(bus.start), 64'd0);
    wait_result(200);

    // Table-driven jobs
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].p, 1'b0, vecs[i].cyc);
      wait_result(200);
    end

    // 5x2 with back-pressure; a second pair offered during HOLD must wait
    bus.out_ready = 1'b0;
    send(16'd5, 16'd2, 32'd10, 1'b0, 32'd4);
    begin
      int n = 0;
      while (!bus.out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    cur_a = 16'd1; cur_b = 16'd1; cur_p = 32'd1; cur_err = 1'b0; cur_cyc = 32'd3;
    bus.in_a = 16'd1;
    bus.in_b = 16'd1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_out_product", 64'(bus.out_product), 64'd10);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    send(16'd1, 16'd1, 32'd1, 1'b0, 32'd3);
    wait_result(200);

    // Timeout: core never raises done
    hang = 1'b1;
    send(16'd2, 16'd3, 32'd0, 1'b1, 32'(MC));
    wait_result(200);
    hang = 1'b0;

    // Reset for one edge mid-RUN, then a clean 6x9 job
    send(16'd4, 16'd5, 32'd20, 1'b0, 32'd7);
    repeat (6) @(negedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_start", 64'(bus.start), 64'd0);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_out_product", 64'(bus.out_product), 64'd0);
    chk("mid_rst_out_cycles", 64'(bus.out_cycles), 64'd0);
    chk("mid_rst_data_in", 64'(bus.data_in), 64'd0);
    send(16'd6, 16'd9, 32'd54, 1'b0, 32'd11);
    wait_result(200);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
